// File: rtl/uk101_loader_pkg.sv
// Shared constants and types for the UK101 ASCII file loader.
//   CR / LF / SUB  : ASCII control codes the input filter acts on
//   loader_state_t : output pacing FSM states
package uk101_loader_pkg;

   localparam logic [7:0] CR  = 8'h0D;
   localparam logic [7:0] LF  = 8'h0A;
   localparam logic [7:0] SUB = 8'h1A;

   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      GAP
   } loader_state_t;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous FIFO, no filtering.
//   clk_sys, reset : clock, synchronous active-high reset
//   push/push_data : write request and data; ignored when full unless popping too
//   pop            : remove head entry; ignored when empty
//   head           : current head entry
//   full/empty     : occupancy flags
//   count          : number of stored entries
module loader_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/ascii_loader.sv
// Paces a host-downloaded ASCII text file into the UK101 ACIA receive path.
//   clk_sys, reset      : clock, synchronous active-high reset
//   enable              : file loading selected; otherwise bytes are discarded
//   ioctl_download/wr/data : hps_io download port; ioctl_wait is registered back-pressure
//   out_valid/data/ready: character stream to the machine (valid/ready handshake)
//   busy                : download active, characters buffered, or pacing in progress
//   overflow            : sticky, a byte was dropped on a full FIFO
//   char_count          : characters delivered since last download start (saturating)
module ascii_loader
   import uk101_loader_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter int unsigned GAP_CYCLES      = 48000,
   parameter int unsigned LINE_GAP_CYCLES = 4800000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        enable,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_data,
   output logic        ioctl_wait,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        overflow,
   output logic [15:0] char_count
);

   localparam int unsigned CntW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CntW-1:0] WaitLevel = CntW'(FIFO_DEPTH - 2);
   localparam logic [31:0] GapLoad     = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] LineGapLoad = 32'(LINE_GAP_CYCLES - 1);

   loader_state_t   state_q, state_d;
   logic [31:0]     gap_q, gap_d;
   logic            dl_q;
   logic            prev_cr_q;
   logic            wrote_any_q;
   logic            last_cr_q;
   logic            inj_q;
   logic            overflow_q;
   logic            wait_q;
   logic [15:0]     char_count_q;

   logic            accept, rise, fall;
   logic            filt_keep;
   logic [7:0]      filt_byte;
   logic            push, pop;
   logic [7:0]      push_data;
   logic [7:0]      fifo_head;
   logic            fifo_full, fifo_empty;
   logic [CntW-1:0] fifo_count;

   assign accept = ioctl_wr & ioctl_download & enable;
   assign rise   = ioctl_download & ~dl_q;
   assign fall   = ~ioctl_download & dl_q;

   // Line-ending normalisation: CRLF -> CR, lone LF -> CR; EOF and 8-bit bytes dropped.
   always_comb begin
      filt_keep = 1'b0;
      filt_byte = ioctl_data;
      if (accept) begin
         if (ioctl_data == LF) begin
            filt_keep = ~prev_cr_q;
            filt_byte = CR;
         end else if (ioctl_data == SUB || ioctl_data[7]) begin
            filt_keep = 1'b0;
         end else begin
            filt_keep = 1'b1;
         end
      end
   end

   assign push      = inj_q | filt_keep;
   assign push_data = inj_q ? CR : filt_byte;

   loader_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = PRESENT;
         end
         PRESENT: begin
            if (out_ready) begin
               pop     = 1'b1;
               gap_d   = (fifo_head == CR) ? LineGapLoad : GapLoad;
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - 32'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= IDLE;
         gap_q        <= '0;
         dl_q         <= 1'b0;
         prev_cr_q    <= 1'b0;
         wrote_any_q  <= 1'b0;
         last_cr_q    <= 1'b0;
         inj_q        <= 1'b0;
         overflow_q   <= 1'b0;
         wait_q       <= 1'b0;
         char_count_q <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         dl_q    <= ioctl_download;
         wait_q  <= enable & (fifo_count >= WaitLevel);
         inj_q   <= fall & wrote_any_q & ~last_cr_q;
         // Download start clears per-file state; a byte in the same cycle still counts.
         if (rise) begin
            prev_cr_q   <= 1'b0;
            wrote_any_q <= 1'b0;
            last_cr_q   <= 1'b0;
            overflow_q  <= 1'b0;
         end
         if (accept) prev_cr_q <= (ioctl_data == CR);
         if (push) begin
            wrote_any_q <= 1'b1;
            last_cr_q   <= (push_data == CR);
         end
         if (push & fifo_full & ~pop) overflow_q <= 1'b1;
         if (rise)                                  char_count_q <= '0;
         else if (pop && char_count_q != 16'hFFFF) char_count_q <= char_count_q + 16'd1;
      end
   end

   assign ioctl_wait = wait_q;
   assign out_valid  = (state_q == PRESENT);
   assign out_data   = out_valid ? fifo_head : 8'h00;
   assign busy       = ioctl_download | ~fifo_empty | (state_q != IDLE) | inj_q;
   assign overflow   = overflow_q;
   assign char_count = char_count_q;

endmodule

// File: tb/tb_ascii_loader.sv
module tb_ascii_loader;

   localparam int unsigned Depth   = 4;
   localparam int unsigned Gap     = 4;
   localparam int unsigned LineGap = 10;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        enable;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wait;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        busy;
   logic        overflow;
   logic [15:0] char_count;

   ascii_loader #(
      .FIFO_DEPTH      (Depth),
      .GAP_CYCLES      (Gap),
      .LINE_GAP_CYCLES (LineGap)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .enable         (enable),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_data     (ioctl_data),
      .ioctl_wait     (ioctl_wait),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .busy           (busy),
      .overflow       (overflow),
      .char_count     (char_count)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int valid_cycles = 0;
   int wait_cycles = 0;
   bit stall_pend = 0;
   logic [7:0] held = 8'h00;
   bit hs_valid = 0;
   int last_hs = 0;
   logic [7:0] last_ch = 8'h00;
   bit rdy_rand = 0;

   logic [7:0] stim_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         hs_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Output monitor: captures handshakes, checks hold-while-stalled and minimum spacing.
   always @(negedge clk_sys) begin
      if (reset) begin
         stall_pend <= 0;
         hs_valid   <= 0;
      end else begin
         if (ioctl_wait) wait_cycles <= wait_cycles + 1;
         if (out_valid)  valid_cycles <= valid_cycles + 1;
         if (stall_pend && out_valid) check("hold_stable", out_data, held);
         stall_pend <= out_valid && !out_ready;
         held       <= out_data;
         if (out_valid && out_ready) begin
            if (hs_valid)
               check("min_spacing",
                     (cyc - last_hs) >= ((last_ch == 8'h0D) ? LineGap + 2 : Gap + 2), 1);
            hs_valid <= 1;
            last_hs  <= cyc;
            last_ch  <= out_data;
            got_q.push_back(out_data);
            hs_q.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic strobe(input logic [7:0] b);
      ioctl_data = b;
      ioctl_wr   = 1'b1;
      tick();
   endtask

   // Reference: the text-file rules applied to a whole download.
   task automatic build_model();
      bit prev_cr;
      prev_cr = 0;
      exp_q.delete();
      foreach (stim_q[i]) begin
         logic [7:0] b;
         b = stim_q[i];
         if (b == 8'h0A) begin
            if (!prev_cr) exp_q.push_back(8'h0D);
         end else if (b != 8'h1A && b < 8'h80) begin
            exp_q.push_back(b);
         end
         prev_cr = (b == 8'h0D);
      end
      if (exp_q.size() > 0 && exp_q[exp_q.size()-1] != 8'h0D) exp_q.push_back(8'h0D);
   endtask

   task automatic send_bytes(input int max_idle);
      int t;
      ioctl_download = 1'b1;
      tick();
      foreach (stim_q[i]) begin
         repeat ($urandom_range(max_idle, 0)) tick();
         t = 0;
         while (ioctl_wait && t < 500) begin
            tick();
            t++;
         end
         if (t >= 500) check("wait_timeout", t, 0);
         strobe(stim_q[i]);
         ioctl_wr = 1'b0;
      end
      ioctl_download = 1'b0;
      tick();
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((got_q.size() < exp_q.size() || busy) && t < 3000) begin
         tick();
         t++;
      end
      repeat (30) tick();
      check("n_chars", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) check("char", got_q[i], exp_q[i]);
   endtask

   function automatic logic [7:0] rand_byte();
      case ($urandom_range(9, 0))
         0, 1, 2, 3, 4: return 8'h41 + 8'($urandom_range(25, 0));
         5:             return 8'h0D;
         6:             return 8'h0A;
         7:             return 8'h1A;
         8:             return 8'h80 | 8'($urandom_range(127, 0));
         default:       return 8'($urandom_range(127, 0));
      endcase
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int v0;
      int w0;
      reset = 1; enable = 1; ioctl_download = 0; ioctl_wr = 0; ioctl_data = 0; out_ready = 0;
      repeat (3) tick();
      reset = 0;
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_wait", ioctl_wait, 0);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_char_count", char_count, 0);

      // Line endings
      out_ready = 1;
      stim_q = '{8'h41, 8'h0D, 8'h0A, 8'h42, 8'h0A, 8'h43};
      build_model();
      got_q.delete();
      send_bytes(2);
      drain();
      check("le_char_count", char_count, 6);

      // Gaps and first-byte latency
      got_q.delete(); hs_q.delete();
      ioctl_download = 1; tick();
      ioctl_data = 8'h58; ioctl_wr = 1; tick();
      check("lat_n1_valid", out_valid, 0);
      ioctl_data = 8'h0D; tick();
      check("lat_n2_valid", out_valid, 1);
      ioctl_data = 8'h59; tick();
      ioctl_wr = 0; ioctl_download = 0; tick();
      exp_q = '{8'h58, 8'h0D, 8'h59, 8'h0D};
      drain();
      if (hs_q.size() == 4) begin
         check("gap_char", hs_q[1] - hs_q[0], Gap + 2);
         check("gap_line", hs_q[2] - hs_q[1], LineGap + 2);
         check("gap_char2", hs_q[3] - hs_q[2], Gap + 2);
      end

      // Back-pressure and overflow
      out_ready = 0;
      got_q.delete();
      ioctl_download = 1; tick();
      strobe(8'h31);
      strobe(8'h32);
      check("bp_wait_at2", ioctl_wait, 0);
      strobe(8'h33);
      check("bp_wait_after2", ioctl_wait, 1);
      strobe(8'h34);
      check("bp_no_ovf", overflow, 0);
      strobe(8'h35);
      ioctl_wr = 0;
      check("bp_ovf", overflow, 1);
      out_ready = 1;
      v0 = 0;
      while (got_q.size() < 1 && v0 < 200) begin tick(); v0++; end
      ioctl_download = 0; tick();
      exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D};
      drain();
      check("bp_ovf_sticky", overflow, 1);

      // Filtering
      got_q.delete();
      stim_q = '{8'h41, 8'h1A, 8'hC1, 8'h42};
      build_model();
      send_bytes(1);
      check("ovf_cleared", overflow, 0);
      drain();
      check("flt_char_count", char_count, 3);

      // enable = 0
      enable = 0;
      got_q.delete();
      v0 = valid_cycles; w0 = wait_cycles;
      ioctl_download = 1; tick();
      check("dis_busy_dl", busy, 1);
      for (int i = 0; i < 6; i++) strobe(8'h41 + 8'(i));
      ioctl_wr = 0; ioctl_download = 0; tick();
      check("dis_busy_idle", busy, 0);
      repeat (30) tick();
      check("dis_no_valid", valid_cycles - v0, 0);
      check("dis_no_wait", wait_cycles - w0, 0);
      check("dis_char_count", char_count, 0);
      enable = 1;

      // Randomized downloads with random consumer stalls
      for (int n = 0; n < 8; n++) begin
         int len;
         len = $urandom_range(14, 1);
         stim_q.delete();
         for (int i = 0; i < len; i++) stim_q.push_back(rand_byte());
         build_model();
         got_q.delete();
         rdy_rand = 1;
         fork
            begin
               while (rdy_rand) begin
                  out_ready = 1'($urandom_range(1, 0));
                  tick();
               end
               out_ready = 1;
            end
         join_none
         send_bytes(3);
         drain();
         rdy_rand = 0;
         repeat (2) tick();
         check("rnd_char_count", char_count, exp_q.size());
         check("rnd_no_ovf", overflow, 0);
      end

      // Reset with bytes buffered and the FSM presenting
      out_ready = 0;
      got_q.delete();
      ioctl_download = 1; tick();
      strobe(8'h61);
      strobe(8'h62);
      strobe(8'h63);
      ioctl_wr = 0;
      check("prerst_valid", out_valid, 1);
      reset = 1; ioctl_download = 0; tick();
      check("midrst_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_count", char_count, 0);
      reset = 0;
      out_ready = 1;
      v0 = valid_cycles;
      repeat (40) tick();
      check("postrst_quiet", valid_cycles - v0, 0);
      check("postrst_none", got_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
